// File: rtl/datapath.sv
// datapath: streams two small matrices W (row_w x col_w) and X (row_x x col_x)
// in row-major order, one 4-bit element per clock, then registers P = W * X
// into the nine o-outputs and raises done until the next clear.
// Optional feature: define DATAPATH_DIM_CHECK_EN to flag illegal dimensions
// (zero dimension or col_w != row_x) on err and force all outputs to 0.

// One dot product of a W row with an X column.
module datapath_dot (
    input  logic [2:0][3:0] a,
    input  logic [2:0][3:0] b,
    output logic [9:0]      sum
);
    // Full 3-term sum; cells beyond the loaded region are zero, so they drop out.
    always_comb begin
        sum = '0;
        for (int k = 0; k < 3; k++)
            sum = sum + 10'(a[k]) * 10'(b[k]);
    end
endmodule

module datapath (
    input  logic       clk,
    input  logic       clear_mem_n,
    input  logic [3:0] data_in,
    input  logic [1:0] row_w,
    input  logic [1:0] col_w,
    input  logic [1:0] row_x,
    input  logic [1:0] col_x,
    output logic [9:0] o11, o12, o13,
    output logic [9:0] o21, o22, o23,
    output logic [9:0] o31, o32, o33,
    output logic       done,
    output logic       err
);
    typedef enum logic [1:0] {LOAD_W, LOAD_X, COMPUTE, DONE} state_t;

    state_t                 state;
    logic [2:0][2:0][3:0]   w, x;        // [row][col]
    logic [2:0][2:0][3:0]   xcol;        // X transposed: [col][row]
    logic [2:0][2:0][9:0]   prod, p;     // [row][col]
    logic [1:0]             rw_q, cw_q, rx_q, cx_q;
    logic                   dims_vld;
    logic [1:0]             r, c;
    logic                   err_q;

    // Dimensions seen by the current edge: live inputs until latched on the first load edge.
    logic [1:0] rw_e, cw_e, rx_e, cx_e;
    assign rw_e = dims_vld ? rw_q : row_w;
    assign cw_e = dims_vld ? cw_q : col_w;
    assign rx_e = dims_vld ? rx_q : row_x;
    assign cx_e = dims_vld ? cx_q : col_x;

    // An empty matrix is skipped so the edge count stays rows*cols for each.
    logic w_empty, x_empty, do_w, do_x, do_comp, illegal;
    logic [1:0] lim_r, lim_c;
    assign w_empty = (rw_e == 2'd0) || (cw_e == 2'd0);
    assign x_empty = (rx_e == 2'd0) || (cx_e == 2'd0);
    assign do_w    = (state == LOAD_W) && !w_empty;
    assign do_x    = ((state == LOAD_X) || ((state == LOAD_W) && w_empty)) && !x_empty;
    assign do_comp = (state == COMPUTE) ||
                     (((state == LOAD_W) || (state == LOAD_X)) && !do_w && !do_x);
    assign lim_r   = do_w ? rw_e - 2'd1 : rx_e - 2'd1;
    assign lim_c   = do_w ? cw_e - 2'd1 : cx_e - 2'd1;

`ifdef DATAPATH_DIM_CHECK_EN
    assign illegal = (rw_e == 2'd0) || (cw_e == 2'd0) || (rx_e == 2'd0) ||
                     (cx_e == 2'd0) || (cw_e != rx_e);
`else
    assign illegal = 1'b0;
`endif

    // Nine dot-product lanes, one per output element.
    for (genvar i = 0; i < 3; i++) begin : g_row
        for (genvar j = 0; j < 3; j++) begin : g_col
            assign xcol[j][i] = x[i][j];
            datapath_dot u_dot (.a(w[i]), .b(xcol[j]), .sum(prod[i][j]));
        end
    end

    // Sequencer: load W, load X, compute once, then hold until cleared.
    always_ff @(posedge clk) begin
        if (!clear_mem_n) begin
            state    <= LOAD_W;
            w        <= '0;
            x        <= '0;
            p        <= '0;
            rw_q     <= '0;
            cw_q     <= '0;
            rx_q     <= '0;
            cx_q     <= '0;
            dims_vld <= 1'b0;
            r        <= '0;
            c        <= '0;
            done     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if ((state == LOAD_W) && !dims_vld) begin
                rw_q     <= row_w;
                cw_q     <= col_w;
                rx_q     <= row_x;
                cx_q     <= col_x;
                dims_vld <= 1'b1;
            end
            if (do_w) w[r][c] <= data_in;
            if (do_x) x[r][c] <= data_in;
            if (do_w || do_x) begin
                if (c == lim_c) begin
                    c <= '0;
                    if (r == lim_r) begin
                        r     <= '0;
                        state <= do_w ? LOAD_X : COMPUTE;
                    end else begin
                        r <= r + 2'd1;
                    end
                end else begin
                    c <= c + 2'd1;
                end
            end
            if (do_comp) begin
                p     <= illegal ? '0 : prod;
                done  <= 1'b1;
                err_q <= illegal;
                state <= DONE;
            end
        end
    end

    assign err = err_q;
    assign o11 = p[0][0]; assign o12 = p[0][1]; assign o13 = p[0][2];
    assign o21 = p[1][0]; assign o22 = p[1][1]; assign o23 = p[1][2];
    assign o31 = p[2][0]; assign o32 = p[2][1]; assign o33 = p[2][2];
endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: hand-computed matrix products, latency,
// reset abort, hold behaviour and the dimension-check option.
module tb_datapath;
    logic       clk = 1'b0;
    logic       clear_mem_n = 1'b0;
    logic [3:0] data_in = '0;
    logic [1:0] row_w = '0, col_w = '0, row_x = '0, col_x = '0;
    logic [9:0] o11, o12, o13, o21, o22, o23, o31, o32, o33;
    logic       done, err;

    int n_vec = 0;
    int n_bad = 0;
    int stim[$];

    datapath dut (
        .clk(clk), .clear_mem_n(clear_mem_n), .data_in(data_in),
        .row_w(row_w), .col_w(col_w), .row_x(row_x), .col_x(col_x),
        .o11(o11), .o12(o12), .o13(o13),
        .o21(o21), .o22(o22), .o23(o23),
        .o31(o31), .o32(o32), .o33(o33),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Compare all nine outputs plus done/err against a row-major expectation.
    task automatic chk_all(input string tag, input int e[9], input int e_done, input int e_err);
        int g[9];
        g = '{int'(o11), int'(o12), int'(o13), int'(o21), int'(o22), int'(o23),
              int'(o31), int'(o32), int'(o33)};
        for (int i = 0; i < 9; i++)
            chk($sformatf("%s_o%0d%0d", tag, i / 3 + 1, i % 3 + 1), g[i], e[i]);
        chk({tag, "_done"}, int'(done), e_done);
        chk({tag, "_err"}, int'(err), e_err);
    endtask

    task automatic do_reset();
        @(negedge clk) clear_mem_n = 1'b0;
        @(negedge clk) clear_mem_n = 1'b1;
    endtask

    // Stream stim[] from the first post-reset edge; optionally scramble the
    // dimension inputs after the first edge (they must already be latched).
    // Ends at the negedge after edge N+1, checking done stays low at edge N.
    task automatic load(input string tag, input logic [1:0] rw, cw, rx, cx, input bit scramble);
        row_w = rw; col_w = cw; row_x = rx; col_x = cx;
        foreach (stim[i]) begin
            data_in = 4'(stim[i]);
            @(negedge clk);
            if (scramble) begin
                row_w = 2'd3; col_w = 2'd3; row_x = 2'd3; col_x = 2'd3;
            end
        end
        chk({tag, "_early_done"}, int'(done), 0);
        data_in = 4'hf;
        @(negedge clk);
    endtask

    int e23[9] = '{41, 45, 49, 87, 96, 105, 125, 138, 151};
    int zero9[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    int e15[9] = '{675, 675, 675, 675, 675, 675, 675, 675, 675};
    int e11[9] = '{63, 0, 0, 0, 0, 0, 0, 0, 0};
    int emis[9];

    initial begin
        // Reset state
        @(negedge clk);
        do_reset();
        chk_all("reset", zero9, 0, 0);

        // 3x2 * 2x3
        stim = '{1, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13};
        load("m32", 2'd3, 2'd2, 2'd2, 2'd3, 1'b0);
        chk_all("m32", e23, 1, 0);

        // Hold: data_in toggles, outputs must not move
        for (int i = 0; i < 10; i++) begin
            data_in = 4'(i * 5 + 3);
            @(negedge clk);
        end
        chk_all("hold", e23, 1, 0);

        // Reset in DONE clears everything
        do_reset();
        chk_all("rst_done", zero9, 0, 0);

        // 3x3 all-15 saturating case
        stim = '{};
        for (int i = 0; i < 18; i++) stim.push_back(15);
        load("m15", 2'd3, 2'd3, 2'd3, 2'd3, 1'b0);
        chk_all("m15", e15, 1, 0);

        // 1x1, dimension inputs change after the first edge
        do_reset();
        stim = '{7, 9};
        load("m11", 2'd1, 2'd1, 2'd1, 2'd1, 1'b1);
        chk_all("m11", e11, 1, 0);

        // Reset after 4 elements, then a clean 3x2 * 2x3 run
        do_reset();
        row_w = 2'd3; col_w = 2'd2; row_x = 2'd2; col_x = 2'd3;
        for (int i = 0; i < 4; i++) begin
            data_in = 4'(i + 11);
            @(negedge clk);
        end
        do_reset();
        chk_all("rst_mid", zero9, 0, 0);
        stim = '{1, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13};
        load("m32b", 2'd3, 2'd2, 2'd2, 2'd3, 1'b0);
        chk_all("m32b", e23, 1, 0);

        // Inner-dimension mismatch 2x3 * 2x2
        do_reset();
        stim = '{1, 2, 3, 4, 5, 6, 1, 2, 3, 4};
        load("mis", 2'd2, 2'd3, 2'd2, 2'd2, 1'b0);
`ifdef DATAPATH_DIM_CHECK_EN
        chk_all("mis", zero9, 1, 1);
`else
        // col_w=3 is the inner dimension; X row 3 was never written (zero)
        emis = '{7, 10, 0, 19, 28, 0, 0, 0, 0};
        chk_all("mis", emis, 1, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 The interface SHALL use one clock; reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 clear_mem_n  input  1  synchronous active-low reset; clears matrices, counters, outputs and FSM.
REQ-004 data_in  input  4  unsigned matrix element, one per clock.
REQ-005 row_w, col_w  input  2 each  rows/columns of W (legal 1..3).
REQ-006 row_x, col_x  input  2 each  rows/columns of X (legal 1..3).
REQ-007 o11..o33  output  10 each  registered product elements P[i][j], i=row, j=column.
REQ-008 done  output  1  high while product outputs are valid.
REQ-009 err  output  1  high when dimensions are illegal (see Configuration).

Function
REQ-010 The FSM SHALL have states LOAD_W, LOAD_X, COMPUTE, DONE; it leaves reset in LOAD_W.
REQ-011 On the first LOAD_W edge, the block SHALL latch row_w, col_w, row_x and col_x; they are held until the next reset.
REQ-012 In LOAD_W, each rising edge SHALL store data_in into W row-major (W11, W12, ..., W1cw, W21, ...) for row_w*col_w edges, then go to LOAD_X.
REQ-013 In LOAD_X, each edge SHALL store data_in into X row-major for row_x*col_x edges, then go to COMPUTE.
REQ-014 In COMPUTE, one edge SHALL register P[i][j] = sum over k=1..col_w of W[i][k]*X[k][j], unsigned, zero-extended to 10 bits (max 3*15*15=675, no overflow), then go to DONE.
REQ-015 Latency: with N = row_w*col_w + row_x*col_x, outputs and done SHALL be valid after edge N+1 following reset release.
REQ-016 Outputs outside the row_w x col_x region SHALL be 0.
REQ-017 In COMPUTE and DONE, data_in SHALL be ignored; DONE holds outputs and done=1 until reset.
REQ-018 Matrix storage cells not written in a load SHALL read as 0.

Reset
REQ-019 clear_mem_n=0 at a rising edge SHALL zero W, X, all o-outputs, done, err and counters, and set state LOAD_W.
REQ-020 Reset asserted mid-load or in DONE SHALL abort the operation with the same result; loading restarts at W11 on the first edge with clear_mem_n=1.

Configuration
REQ-021 With DATAPATH_DIM_CHECK_EN defined, a zero dimension or col_w != row_x SHALL cause: loading proceeds normally, COMPUTE writes all outputs 0, and err=1 together with done=1.
REQ-022 Without DATAPATH_DIM_CHECK_EN, err SHALL be tied 0 and col_w SHALL be used as the inner dimension regardless of row_x; behaviour with a zero dimension is unspecified.

Verification
REQ-023 3x2 * 2x3 case: dims 3,2,2,3; stream 1,3,4,5,6,7,8,9,10,11,12,13 -> after edge 13: rows 41 45 49 / 87 96 105 / 125 138 151, done=1.
REQ-024 3x3 all-15 case: 18 elements of 15 -> all nine outputs = 675 after edge 19.
REQ-025 1x1 case: dims 1,1,1,1; stream 7, 9 -> o11=63, others 0, done after edge 3.
REQ-026 Reset mid-load: assert clear_mem_n=0 after 4 elements, release, stream the REQ-023 data -> identical REQ-023 result.
REQ-027 Mismatch case with DATAPATH_DIM_CHECK_EN: dims 2,3,2,2 -> after load (6+4 edges) and compute, err=1, done=1, all outputs 0.
REQ-028 Hold case: after REQ-023 completes, keep toggling data_in for 10 cycles -> outputs unchanged.
